// File: rtl/qnigma_buf_reader_pkg.sv
// Shared types for the packet-buffer read engine: FSM encoding, skid FIFO depth and entry layout.
package qnigma_buf_reader_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle  = 2'd0;
    localparam state_t StRead  = 2'd1;
    localparam state_t StDrain = 2'd2;
    localparam state_t StDone  = 2'd3;

    localparam int unsigned FifoDepth = 3;

    // The stream word width of every instance must equal EntryDw.
    localparam int unsigned EntryDw = 16;

    typedef struct packed {
        logic [EntryDw-1:0] dat;
        logic               sof;
        logic               eof;
    } fifo_entry_t;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(FifoDepth - 1)) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/qnigma_skid_fifo.sv
// Three-entry register FIFO that soaks up the RAM read latency; head is a plain register read.
module qnigma_skid_fifo
    import qnigma_buf_reader_pkg::*;
#(
    parameter int unsigned Width = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [Width-1:0] push_dat,
    input  logic             pop,
    output logic [Width-1:0] head,
    output logic [1:0]       occ
);

    logic [Width-1:0] mem_q [FifoDepth];
    logic [1:0]       wr_q;
    logic [1:0]       rd_q;
    logic [1:0]       occ_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (occ_q != 2'(FifoDepth));
    assign do_pop  = pop && (occ_q != 2'd0);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_q  <= 2'd0;
            rd_q  <= 2'd0;
            occ_q <= 2'd0;
        end else begin
            if (do_push) begin
                wr_q <= ptr_inc(wr_q);
            end
            if (do_pop) begin
                rd_q <= ptr_inc(rd_q);
            end
            occ_q <= occ_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Storage needs no reset; occupancy alone says which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= push_dat;
        end
    end

    assign head = mem_q[rd_q];
    assign occ  = occ_q;

endmodule

// File: rtl/qnigma_buf_reader.sv
// Packet buffer read engine: walks the RAM read port for one command and streams the words
// out with sof/eof framing, using a 3-entry skid FIFO so out_rdy never reaches ram_a.
module qnigma_buf_reader
    import qnigma_buf_reader_pkg::*;
#(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = EntryDw,
    parameter int unsigned LW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_val,
    output logic          cmd_rdy,
    input  logic [AW-1:0] cmd_addr,
    input  logic [LW-1:0] cmd_len,
    input  logic          abort,
    output logic [AW-1:0] ram_a,
    input  logic [DW-1:0] ram_q,
    output logic [DW-1:0] out_dat,
    output logic          out_val,
    output logic          out_sof,
    output logic          out_eof,
    input  logic          out_rdy,
    output logic          busy,
    output logic          done
);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] ram_a_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] issue_cnt_q;
    logic [LW-1:0] emit_cnt_q;
    logic          inflight_q;
    logic          infl_sof_q;
    logic          infl_eof_q;

    logic          hs;
    logic          kill;
    logic          credit_ok;
    logic          issue;
    logic          push;
    logic          pop;
    logic [1:0]    occ;
    fifo_entry_t   push_e;
    fifo_entry_t   head_e;

    assign cmd_rdy = (state_q == StIdle) && !rst;
    assign hs      = cmd_val && cmd_rdy;
    assign kill    = abort && (state_q != StIdle);
    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StDone);

    // Credit counts words already buffered plus the one still coming back from the RAM.
    assign credit_ok = ({1'b0, occ} + {2'b0, inflight_q}) < 3'(FifoDepth);
    assign issue     = (state_q == StRead) && (issue_cnt_q != '0) && credit_ok && !kill;
    assign ram_a     = issue ? addr_q : ram_a_q;

    assign push   = inflight_q && !kill;
    assign push_e = '{dat: ram_q, sof: infl_sof_q, eof: infl_eof_q};

    assign out_val = (occ != 2'd0);
    assign pop     = out_val && out_rdy;
    assign out_dat = out_val ? head_e.dat : '0;
    assign out_sof = out_val && head_e.sof;
    assign out_eof = out_val && head_e.eof;

    qnigma_skid_fifo #(
        .Width($bits(fifo_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (kill),
        .push    (push),
        .push_dat(push_e),
        .pop     (pop),
        .head    (head_e),
        .occ     (occ)
    );

    always_comb begin
        state_d = state_q;
        if (kill) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (hs) state_d = (cmd_len == '0) ? StDone : StRead;
                StRead:  if (issue_cnt_q == '0) state_d = StDrain;
                StDrain: if (pop && (emit_cnt_q == LW'(1))) state_d = StDone;
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            ram_a_q     <= '0;
            len_q       <= '0;
            issue_cnt_q <= '0;
            emit_cnt_q  <= '0;
            inflight_q  <= 1'b0;
            infl_sof_q  <= 1'b0;
            infl_eof_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= issue;
            ram_a_q    <= ram_a;
            if (issue) begin
                addr_q      <= addr_q + AW'(1);
                issue_cnt_q <= issue_cnt_q - LW'(1);
                infl_sof_q  <= (issue_cnt_q == len_q);
                infl_eof_q  <= (issue_cnt_q == LW'(1));
            end
            if (hs) begin
                addr_q      <= cmd_addr;
                len_q       <= cmd_len;
                issue_cnt_q <= cmd_len;
                emit_cnt_q  <= cmd_len;
            end else if (pop && (emit_cnt_q != '0)) begin
                emit_cnt_q <= emit_cnt_q - LW'(1);
            end
        end
    end

endmodule

// File: tb/tb_qnigma_buf_reader.sv
// Directed bench for qnigma_buf_reader with a behavioural 1-cycle-latency RAM.
module tb_qnigma_buf_reader;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned LW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_val = 1'b0;
    logic          abort = 1'b0;
    logic          out_rdy = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          cmd_rdy, out_val, out_sof, out_eof, busy, done;
    logic [AW-1:0] ram_a;
    logic [DW-1:0] ram_q;
    logic [DW-1:0] out_dat;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // RAM contents: A0..A3 at 0x10..0x13, an address-derived pattern elsewhere.
    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        if (a >= 16'h0010 && a <= 16'h0013) return 16'h00A0 + (a - 16'h0010);
        return a ^ 16'h5A5A;
    endfunction

    always @(posedge clk) ram_q <= mem_f(ram_a);

    qnigma_buf_reader #(
        .AW(AW),
        .DW(DW),
        .LW(LW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cmd_val (cmd_val),
        .cmd_rdy (cmd_rdy),
        .cmd_addr(cmd_addr),
        .cmd_len (cmd_len),
        .abort   (abort),
        .ram_a   (ram_a),
        .ram_q   (ram_q),
        .out_dat (out_dat),
        .out_val (out_val),
        .out_sof (out_sof),
        .out_eof (out_eof),
        .out_rdy (out_rdy),
        .busy    (busy),
        .done    (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Returns at the negedge of the first cycle after the handshake.
    task automatic send_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l);
        int w = 0;
        while (!cmd_rdy && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("cmd_rdy_wait", 32'(cmd_rdy), 32'd1);
        cmd_addr = a;
        cmd_len  = l;
        cmd_val  = 1'b1;
        @(negedge clk);
        cmd_val = 1'b0;
    endtask

    // mode 0: out_rdy always high; mode 1: random 50% with a 10-cycle stall mid-packet.
    task automatic collect(input logic [AW-1:0] addr, input int len, input int mode,
                           input int stop_after);
        int            got = 0;
        int            cyc = 1;
        int            first = -1;
        int            stall_left = 0;
        bit            stalled_once = 1'b0;
        logic          prev_stall = 1'b0;
        logic [DW+1:0] prev_word = '0;
        logic [AW-1:0] ea;
        while (got < stop_after && cyc < 300) begin
            if (mode == 1) begin
                if (got == 6 && !stalled_once) begin
                    stalled_once = 1'b1;
                    stall_left   = 10;
                end
                if (stall_left > 0) begin
                    out_rdy = 1'b0;
                    stall_left--;
                end else begin
                    out_rdy = ($urandom_range(0, 1) != 0);
                end
            end else begin
                out_rdy = 1'b1;
            end
            if (mode == 0 && len <= 4 && cyc <= len) begin
                ea = addr + AW'(cyc - 1);
                check("ram_a", 32'(ram_a), 32'(ea));
            end
            if (prev_stall) begin
                check("stall_hold", 32'({out_val, out_sof, out_eof, out_dat}),
                      32'({1'b1, prev_word}));
            end
            if (out_val && first < 0) begin
                first = cyc;
                if (mode == 0) check("first_latency", 32'(cyc), 32'd3);
            end
            if (out_val && out_rdy) begin
                ea = addr + AW'(got);
                check("dat", 32'(out_dat), 32'(mem_f(ea)));
                check("sof", 32'(out_sof), 32'(got == 0));
                check("eof", 32'(out_eof), 32'(got == len - 1));
                if (mode == 0) check("throughput", 32'(cyc), 32'(3 + got));
                got++;
            end
            prev_stall = out_val && !out_rdy;
            prev_word  = {out_sof, out_eof, out_dat};
            @(negedge clk);
            cyc++;
        end
        check("word_count", 32'(got), 32'(stop_after));
        out_rdy = 1'b0;
        if (stop_after == len) begin
            check("done_pulse", 32'(done), 32'd1);
            check("val_after_eof", 32'(out_val), 32'd0);
            @(negedge clk);
            check("done_clear", 32'(done), 32'd0);
            check("cmd_rdy_back", 32'(cmd_rdy), 32'd1);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_val", 32'(out_val), 32'd0);
        check("rst_sof_eof", 32'({out_sof, out_eof}), 32'd0);
        check("rst_done_busy", 32'({done, busy}), 32'd0);
        check("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
        check("rst_dat", 32'(out_dat), 32'd0);
        check("rst_ram_a", 32'(ram_a), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("cmd_rdy_after_rst", 32'(cmd_rdy), 32'd1);

        // Basic four-word read.
        send_cmd(16'h0010, 16'd4);
        collect(16'h0010, 4, 0, 4);

        // Address wrap 0xFFFE, 0xFFFF, 0x0000, 0x0001.
        send_cmd(16'hFFFE, 16'd4);
        collect(16'hFFFE, 4, 0, 4);

        // Zero length: straight to the done pulse with no data.
        send_cmd(16'h0040, 16'd0);
        check("zero_done", 32'(done), 32'd1);
        check("zero_val", 32'(out_val), 32'd0);
        @(negedge clk);
        check("zero_cmd_rdy", 32'(cmd_rdy), 32'd1);
        check("zero_done_clear", 32'(done), 32'd0);

        // Single word carries both markers.
        send_cmd(16'h0050, 16'd1);
        collect(16'h0050, 1, 0, 1);

        // Random backpressure with a long stall.
        send_cmd(16'h0100, 16'd16);
        collect(16'h0100, 16, 1, 16);

        // Abort after three accepted words, then a fresh short packet.
        send_cmd(16'h0200, 16'd8);
        collect(16'h0200, 8, 0, 3);
        abort = 1'b1;
        check("abort_cyc_done", 32'(done), 32'd0);
        @(negedge clk);
        abort = 1'b0;
        check("abort_val", 32'(out_val), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_cmd_rdy", 32'(cmd_rdy), 32'd1);
        check("abort_no_done", 32'(done), 32'd0);
        @(negedge clk);
        check("abort_no_done2", 32'({done, out_val}), 32'd0);
        send_cmd(16'h0300, 16'd2);
        collect(16'h0300, 2, 0, 2);

        // Reset in the middle of a read.
        send_cmd(16'h0400, 16'd8);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_val", 32'(out_val), 32'd0);
        check("mid_rst_sof_eof", 32'({out_sof, out_eof}), 32'd0);
        check("mid_rst_done_busy", 32'({done, busy}), 32'd0);
        check("mid_rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
        check("mid_rst_dat", 32'(out_dat), 32'd0);
        check("mid_rst_ram_a", 32'(ram_a), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_cmd_rdy_after", 32'(cmd_rdy), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/qnigma_buf_reader.md
Name: qnigma_buf_reader

Overview:
Read-side engine for the team's dual-port packet buffer RAM. It accepts a command holding a start address and a word count. It then drives the RAM read port (fixed 1-cycle read latency) and streams the words out on a valid/ready interface with start-of-frame and end-of-frame markers. An internal 3-entry skid FIFO absorbs the RAM latency so that out_rdy never feeds the RAM address path combinationally, while keeping full throughput.

Parameters:
AW, 16, RAM address width; addresses wrap modulo 2**AW
DW, 16, data word width (matches RAM DW)
LW, 16, command length field width (words)

Ports:
clk       in   1    clock
rst       in   1    synchronous active-high reset
cmd_val   in   1    command valid
cmd_rdy   out  1    command ready (high only in IDLE, rst low)
cmd_addr  in   AW   first word address
cmd_len   in   LW   word count; 0 allowed
abort     in   1    cancel current packet
ram_a     out  AW   RAM read address
ram_q     in   DW   RAM read data, valid 1 cycle after ram_a
out_dat   out  DW   stream data
out_val   out  1    stream valid
out_sof   out  1    first word of packet
out_eof   out  1    last word of packet
out_rdy   in   1    stream ready
busy      out  1    state != IDLE
done      out  1    1-cycle pulse at packet completion

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst.
- Reset: state IDLE; out_val, out_sof, out_eof, done, busy, cmd_rdy = 0; out_dat = 0; ram_a = 0; FIFO empty; in-flight flag cleared. cmd_rdy rises in the first cycle after rst deasserts.
- Command handshake: cmd_val && cmd_rdy. Latch addr and len. Words-to-issue counter = len; words-to-emit counter = len.
- States:
  - IDLE: on handshake, go to READ if len != 0; if len == 0, go to DONE.
  - READ: issue reads until issue counter is 0, then go to DRAIN.
  - DRAIN: wait for the final handshake on the out_eof word, then go to DONE.
  - DONE: assert done for 1 cycle, then return to IDLE.
- Read issue in READ:
  - Issue when issue_cnt != 0 and (fifo_occ + inflight) < 3.
  - On issue: ram_a = addr counter; addr counter increments (AW-bit wrap, 2**AW-1 -> 0); issue_cnt decrements; inflight is set for the next cycle.
  - ram_q is pushed into the FIFO in the cycle after the issue.
- Timing:
  - First read issued in the cycle after cmd handshake.
  - out_val is first high 3 cycles after the handshake cycle.
  - Sustained throughput with out_rdy held high is 1 word/cycle.
- Stream rules:
  - out_dat, out_sof and out_eof are stable while out_val && !out_rdy.
  - out_sof is high on emitted word 1 only; out_eof is high on emitted word len only.
  - For len == 1, sof and eof are high on the same word.
  - out_val never drops without a handshake, except on abort or rst.
- Backpressure: out_rdy low for any duration causes no data loss or duplication. Reads stall on the credit rule.
- abort (any non-IDLE state):
  - Next cycle: state IDLE, FIFO flushed, in-flight data discarded, out_val = 0, no done pulse.
  - abort in IDLE is ignored. abort has priority over a same-cycle handshake.
- rst mid-packet: identical to the reset values above. The partial packet is lost.
- cmd_val while busy: not accepted (cmd_rdy = 0).
- ram_a holds its last value when no read is issued. The RAM is never written by this block.

Decomposition:
- Package qnigma_buf_reader_pkg holds:
  - the state enum (IDLE, READ, DRAIN, DONE);
  - the FIFO depth localparam (3);
  - the FIFO entry struct {dat, sof, eof}.
- Sub-module qnigma_skid_fifo: a 3-entry register FIFO with push/pop, occupancy output and synchronous flush. Parameterised on entry width.

Test Plan:
- Basic read: RAM[0x10..0x13] = A0..A3; cmd addr=0x10, len=4, out_rdy=1 -> A0..A3 on 4 consecutive cycles; first out_val 3 cycles after handshake; sof on A0, eof on A3; done 1 cycle after the A3 handshake.
- Wrap-around: AW=4; cmd addr=0xE, len=4 -> ram_a sequence E, F, 0, 1; data in the same order.
- Zero and single length:
  - len=0 -> no out_val; done pulses; cmd_rdy returns.
  - len=1 -> one word with sof = eof = 1.
- Backpressure: len=16, out_rdy toggled by a random 50% pattern and held low for 10 cycles mid-packet -> exactly 16 words in order; FIFO occupancy never exceeds 3; out_dat stable while stalled.
- Abort: len=8; abort after 3 words are accepted -> out_val low next cycle; no done pulse. A new cmd len=2 then yields only its 2 words, with none of the stale data.
- Reset mid-packet: rst pulsed during the READ state -> all outputs match the reset values in the following cycle; cmd_rdy is high in the cycle after rst falls.
